// File: rtl/cep_noc_packer_pkg.sv
// Shared CEP package geometry, NoC header field positions and packer state encoding.
package cep_noc_packer_pkg;

    localparam int CEP_WORD_WIDTH      = 64;
    localparam int CEP_MAX_WORDS       = 8;
    localparam int CEP_DATA_WIDTH      = CEP_WORD_WIDTH * CEP_MAX_WORDS;
    localparam int CEP_WORDS_CNT_WIDTH = 4;
    localparam int CEP_REQ_HDR_WORDS   = 3;
    localparam int CEP_RESP_HDR_WORDS  = 1;

    // Field positions inside header word 0.
    localparam int CEP_IS_REQ     = 63;
    localparam int CEP_LENGTH_LSB = 22;
    localparam int CEP_LENGTH_MSB = 29;

    typedef enum logic [1:0] {
        CEP_PK_IDLE    = 2'd0,
        CEP_PK_COLLECT = 2'd1,
        CEP_PK_SEND    = 2'd2
    } cep_pk_state_e;

    // Header plus payload flits, clipped to the package capacity.
    function automatic logic [CEP_WORDS_CNT_WIDTH-1:0] words_for_len(input logic [7:0] len);
        if (len >= 8'(CEP_MAX_WORDS - 1))
            return CEP_WORDS_CNT_WIDTH'(CEP_MAX_WORDS);
        else
            return CEP_WORDS_CNT_WIDTH'(len + 8'd1);
    endfunction

endpackage

// File: rtl/cep_noc_packer.sv
// Collects one NoC packet (header + L flits) into a single eight-word CEP package.
module cep_noc_packer
    import cep_noc_packer_pkg::*;
#(
    parameter bit IS_REQ = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           noc_in_val,
    input  logic [CEP_WORD_WIDTH-1:0]      noc_in_data,
    output logic                           noc_in_rdy,
    output logic                           cep_out_val,
    output logic [CEP_DATA_WIDTH-1:0]      cep_out_pkg,
    input  logic                           cep_out_rdy,
    output logic [CEP_WORDS_CNT_WIDTH-1:0] cep_out_words,
    output logic                           err_overflow
);

    cep_pk_state_e                  state_reg;
    logic [CEP_WORD_WIDTH-1:0]      word_reg [CEP_MAX_WORDS];
    logic [7:0]                     len_reg;
    logic [7:0]                     remaining_reg;
    logic [3:0]                     idx_reg;
    logic                           val_reg;
    logic                           err_reg;
    logic [CEP_WORDS_CNT_WIDTH-1:0] words_reg;

    logic [CEP_WORD_WIDTH-1:0]      hdr_next;
    logic [7:0]                     hdr_len;
    logic [CEP_MAX_WORDS-1:1]       word_we;

    always_comb begin
        hdr_next             = noc_in_data;
        hdr_next[CEP_IS_REQ] = IS_REQ;
        hdr_len              = noc_in_data[CEP_LENGTH_MSB:CEP_LENGTH_LSB];
    end

    // One-hot payload word select; idx 8 means the package is full and flits are dropped.
    always_comb begin
        word_we = '0;
        if (state_reg == CEP_PK_COLLECT && noc_in_val) begin
            for (int i = 1; i < CEP_MAX_WORDS; i++)
                word_we[i] = (idx_reg == 4'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= CEP_PK_IDLE;
            len_reg       <= '0;
            remaining_reg <= '0;
            idx_reg       <= '0;
            val_reg       <= 1'b0;
            err_reg       <= 1'b0;
            words_reg     <= '0;
            for (int i = 0; i < CEP_MAX_WORDS; i++)
                word_reg[i] <= '0;
        end else begin
            case (state_reg)
                CEP_PK_IDLE: begin
                    if (noc_in_val) begin
                        word_reg[0] <= hdr_next;
                        for (int i = 1; i < CEP_MAX_WORDS; i++)
                            word_reg[i] <= '0;
                        err_reg <= 1'b0;
                        len_reg <= hdr_len;
                        if (hdr_len == 8'd0) begin
                            state_reg <= CEP_PK_SEND;
                            val_reg   <= 1'b1;
                            words_reg <= words_for_len(8'd0);
                        end else begin
                            state_reg     <= CEP_PK_COLLECT;
                            remaining_reg <= hdr_len;
                            idx_reg       <= 4'd1;
                        end
                    end
                end
                CEP_PK_COLLECT: begin
                    if (noc_in_val) begin
                        for (int i = 1; i < CEP_MAX_WORDS; i++) begin
                            if (word_we[i])
                                word_reg[i] <= noc_in_data;
                        end
                        if (idx_reg == 4'(CEP_MAX_WORDS))
                            err_reg <= 1'b1;
                        else
                            idx_reg <= idx_reg + 4'd1;
                        remaining_reg <= remaining_reg - 8'd1;
                        if (remaining_reg == 8'd1) begin
                            state_reg <= CEP_PK_SEND;
                            val_reg   <= 1'b1;
                            words_reg <= words_for_len(len_reg);
                        end
                    end
                end
                CEP_PK_SEND: begin
                    if (cep_out_rdy) begin
                        state_reg <= CEP_PK_IDLE;
                        val_reg   <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= CEP_PK_IDLE;
                    val_reg   <= 1'b0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < CEP_MAX_WORDS; gi++) begin : g_pack
        assign cep_out_pkg[gi*CEP_WORD_WIDTH +: CEP_WORD_WIDTH] = word_reg[gi];
    end

    assign noc_in_rdy    = (state_reg != CEP_PK_SEND);
    assign cep_out_val   = val_reg;
    assign cep_out_words = words_reg;
    assign err_overflow  = err_reg;

endmodule
